// File: rtl/sensor_packet_tx.sv
// Framer for the 8-byte sensor status packet streamed into the UART transmitter.
// Snapshots the fields at packet start, appends an additive checksum, waits for a 0x55 ACK and retries on timeout.
module sensor_packet_tx #(
    parameter int PERIOD_CYCLES = 50000000,
    parameter int ACK_TIMEOUT   = 200000,
    parameter int MAX_RETRY     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_req,
    input  logic [1:0] sensor_temp,
    input  logic [1:0] sensor_humidity,
    input  logic [1:0] sensor_light,
    input  logic [1:0] sensor_soil,
    input  logic [7:0] fault_flags,
    input  logic [7:0] actuator_status,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       busy,
    output logic       pkt_done,
    output logic       pkt_fail,
    output logic [2:0] retry_cnt,
    output logic [7:0] pkt_count,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND     = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(ACK_TIMEOUT - 1);
    localparam logic [2:0]  RETRY_LIMIT  = 3'(MAX_RETRY);
    localparam bit          PERIOD_EN    = (PERIOD_CYCLES != 0);
    localparam logic [7:0]  SYNC_BYTE    = 8'hAA;
    localparam logic [7:0]  ACK_BYTE     = 8'h55;

    state_t      r_state;
    logic [31:0] r_period_cnt;
    logic [31:0] r_to_cnt;
    logic        r_pending;
    logic        r_ack_seen;
    logic [2:0]  r_idx;
    logic [2:0]  r_retry;
    logic [7:0]  r_pkt_count;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_done;
    logic        r_fail;
    logic [1:0]  r_temp;
    logic [1:0]  r_hum;
    logic [1:0]  r_light;
    logic [1:0]  r_soil;
    logic [7:0]  r_faults;
    logic [7:0]  r_act;
    logic [7:0]  r_csum;

    logic        w_period_hit;
    logic        w_trigger;
    logic        w_ack_rx;
    logic        w_xfer;
    logic [2:0]  w_next_idx;
    logic [7:0]  w_next_byte;
    logic [7:0]  w_csum;

    // Handshake: a byte moves on any cycle with tx_valid && tx_ready; until then
    // tx_valid and tx_data hold, and tx_valid only drops after a transfer or on reset.
    assign w_xfer       = r_tx_valid && tx_ready;
    assign w_period_hit = PERIOD_EN && (r_period_cnt == PERIOD_LAST);
    assign w_trigger    = send_req || w_period_hit;
    assign w_ack_rx     = rx_valid && (rx_data == ACK_BYTE);
    assign w_next_idx   = r_idx + 3'd1;
    assign w_csum       = {6'b0, sensor_temp} + {6'b0, sensor_humidity} + {6'b0, sensor_light}
                        + {6'b0, sensor_soil} + fault_flags + actuator_status;

    always_comb begin
        w_next_byte = SYNC_BYTE;
        case (w_next_idx)
            3'd1:    w_next_byte = {6'b0, r_temp};
            3'd2:    w_next_byte = {6'b0, r_hum};
            3'd3:    w_next_byte = {6'b0, r_light};
            3'd4:    w_next_byte = {6'b0, r_soil};
            3'd5:    w_next_byte = r_faults;
            3'd6:    w_next_byte = r_act;
            3'd7:    w_next_byte = r_csum;
            default: w_next_byte = SYNC_BYTE;
        endcase
    end

    // Free-running trigger timer; keeps counting while a packet is in flight.
    always_ff @(posedge clk) begin
        if (rst || !PERIOD_EN) begin
            r_period_cnt <= '0;
        end else if (w_period_hit) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_to_cnt    <= '0;
            r_pending   <= 1'b0;
            r_ack_seen  <= 1'b0;
            r_idx       <= '0;
            r_retry     <= '0;
            r_pkt_count <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_temp      <= '0;
            r_hum       <= '0;
            r_light     <= '0;
            r_soil      <= '0;
            r_faults    <= '0;
            r_act       <= '0;
            r_csum      <= '0;
        end else begin
            r_done <= 1'b0;
            r_fail <= 1'b0;
            if (w_ack_rx && (r_state != S_IDLE)) begin
                r_ack_seen <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_trigger || r_pending) begin
                        r_temp     <= sensor_temp;
                        r_hum      <= sensor_humidity;
                        r_light    <= sensor_light;
                        r_soil     <= sensor_soil;
                        r_faults   <= fault_flags;
                        r_act      <= actuator_status;
                        r_csum     <= w_csum;
                        r_idx      <= '0;
                        r_retry    <= '0;
                        r_ack_seen <= 1'b0;
                        r_pending  <= 1'b0;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= SYNC_BYTE;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_trigger) begin
                        r_pending <= 1'b1;
                    end
                    if (w_xfer) begin
                        if (r_idx == 3'd7) begin
                            r_tx_valid <= 1'b0;
                            r_to_cnt   <= '0;
                            r_state    <= S_WAIT_ACK;
                        end else begin
                            r_idx     <= w_next_idx;
                            r_tx_data <= w_next_byte;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (w_trigger) begin
                        r_pending <= 1'b1;
                    end
                    // An ACK landing on the timeout cycle still counts as delivered.
                    if (r_ack_seen || w_ack_rx) begin
                        r_done      <= 1'b1;
                        r_pkt_count <= r_pkt_count + 8'd1;
                        r_state     <= S_IDLE;
                    end else if (r_to_cnt == TIMEOUT_LAST) begin
                        if (r_retry < RETRY_LIMIT) begin
                            r_retry    <= r_retry + 3'd1;
                            r_idx      <= '0;
                            r_ack_seen <= 1'b0;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= SYNC_BYTE;
                            r_state    <= S_SEND;
                        end else begin
                            r_fail  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 32'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign busy      = (r_state != S_IDLE);
    assign pkt_done  = r_done;
    assign pkt_fail  = r_fail;
    assign retry_cnt = r_retry;
    assign pkt_count = r_pkt_count;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_sensor_packet_tx.sv
// Bench for sensor_packet_tx: one instance with periodic sending off and a short ACK timeout,
// a second with a 100-cycle period for the periodic-trigger and mid-packet reset cases.
module tb_sensor_packet_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic       rst_p;
    logic       send_req;
    logic [1:0] sensor_temp, sensor_humidity, sensor_light, sensor_soil;
    logic [7:0] fault_flags, actuator_status;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;

    logic [7:0] tx_data, pkt_count;
    logic       tx_valid, busy, pkt_done, pkt_fail;
    logic [2:0] retry_cnt;
    logic [1:0] dbg_state;

    logic [7:0] tx_data_p, pkt_count_p;
    logic       tx_valid_p, busy_p, pkt_done_p, pkt_fail_p;
    logic [2:0] retry_cnt_p;
    logic [1:0] dbg_state_p;

    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    int         fail_cnt = 0;
    int         max_retry_seen = 0;
    logic [7:0] last_byte = 8'h00;
    logic       stalled_prev = 1'b0;

    always #5 clk = ~clk;

    sensor_packet_tx #(.PERIOD_CYCLES(0), .ACK_TIMEOUT(16), .MAX_RETRY(2)) dut (
        .clk(clk), .rst(rst), .send_req(send_req),
        .sensor_temp(sensor_temp), .sensor_humidity(sensor_humidity),
        .sensor_light(sensor_light), .sensor_soil(sensor_soil),
        .fault_flags(fault_flags), .actuator_status(actuator_status),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .pkt_done(pkt_done), .pkt_fail(pkt_fail), .retry_cnt(retry_cnt),
        .pkt_count(pkt_count), .dbg_state(dbg_state)
    );

    sensor_packet_tx #(.PERIOD_CYCLES(100), .ACK_TIMEOUT(16), .MAX_RETRY(2)) dut_p (
        .clk(clk), .rst(rst_p), .send_req(send_req),
        .sensor_temp(sensor_temp), .sensor_humidity(sensor_humidity),
        .sensor_light(sensor_light), .sensor_soil(sensor_soil),
        .fault_flags(fault_flags), .actuator_status(actuator_status),
        .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy_p),
        .pkt_done(pkt_done_p), .pkt_fail(pkt_fail_p), .retry_cnt(retry_cnt_p),
        .pkt_count(pkt_count_p), .dbg_state(dbg_state_p)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pkt_byte(input int idx, input logic [1:0] t, input logic [1:0] h,
                                            input logic [1:0] l, input logic [1:0] s,
                                            input logic [7:0] f, input logic [7:0] a);
        logic [7:0] sum;
        sum = {6'b0, t} + {6'b0, h} + {6'b0, l} + {6'b0, s} + f + a;
        case (idx)
            0: return 8'hAA;
            1: return {6'b0, t};
            2: return {6'b0, h};
            3: return {6'b0, l};
            4: return {6'b0, s};
            5: return f;
            6: return a;
            default: return sum;
        endcase
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [1:0] t, input logic [1:0] h, input logic [1:0] l,
                              input logic [1:0] s, input logic [7:0] f, input logic [7:0] a);
        sensor_temp = t; sensor_humidity = h; sensor_light = l; sensor_soil = s;
        fault_flags = f; actuator_status = a;
    endtask

    task automatic push_packet();
        for (int i = 0; i < 8; i++)
            exp_q.push_back(pkt_byte(i, sensor_temp, sensor_humidity, sensor_light, sensor_soil,
                                     fault_flags, actuator_status));
    endtask

    task automatic pulse_send();
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_q(input int left, input int budget, input string tag);
        int n;
        n = 0;
        while ((exp_q.size() > left || tx_valid) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check(tag, exp_q.size(), left);
    endtask

    // Scoreboard monitor: every presented byte must match the queue front until it is accepted.
    always @(negedge clk) begin
        if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) check("valid_hold", tx_valid, 1);
            if (tx_valid) begin
                check("busy_in_send", busy, 1);
                if (exp_q.size() == 0) begin
                    check("tx_unexpected_byte", exp_q.size(), 1);
                end else begin
                    check("tx_byte", tx_data, exp_q[0]);
                    if (tx_ready) begin
                        last_byte = tx_data;
                        void'(exp_q.pop_front());
                    end
                end
            end
            stalled_prev = tx_valid && !tx_ready;
            if (pkt_done) done_cnt++;
            if (pkt_fail) fail_cnt++;
            if (int'(retry_cnt) > max_retry_seen) max_retry_seen = int'(retry_cnt);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, done0, fail0;
        rst = 1'b1; rst_p = 1'b1; send_req = 1'b0; tx_ready = 1'b1;
        rx_data = 8'h00; rx_valid = 1'b0;
        set_fields(2'd0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00);
        tick(3);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_pkt_fail", pkt_fail, 0);
        check("rst_retry_cnt", retry_cnt, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        tick(2);

        // Basic packet, full rate, checksum 0x0D
        set_fields(2'd2, 2'd2, 2'd2, 2'd2, 8'h00, 8'h05);
        push_packet();
        pulse_send();
        n = 0;
        while (tx_valid && n < 20) begin tick(); n++; end
        check("b2b_cycles", n, 8);
        check("csum_basic", last_byte, 8'h0D);
        check("wait_ack_state", dbg_state, 2);
        check("wait_ack_busy", busy, 1);
        done0 = done_cnt;
        send_rx(8'h55);
        tick(2);
        check("done_pulse_1", done_cnt - done0, 1);
        check("pkt_count_1", pkt_count, 1);
        check("idle_busy_1", busy, 0);

        // All-ones fields, checksum wraps to 0x0A
        set_fields(2'd3, 2'd3, 2'd3, 2'd3, 8'hFF, 8'hFF);
        push_packet();
        pulse_send();
        wait_q(0, 40, "drain_timeout_2");
        check("csum_wrap", last_byte, 8'h0A);
        send_rx(8'h55);
        tick(2);
        check("pkt_count_2", pkt_count, 2);

        // Stalled transmitter with inputs changing mid-packet
        set_fields(2'd1, 2'd0, 2'd3, 2'd2, 8'h5A, 8'hC3);
        push_packet();
        pulse_send();
        tx_ready = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || tx_valid) && n < 60) begin
            set_fields(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            tick();
            tx_ready = ~tx_ready;
            n++;
        end
        if (n >= 60) check("drain_timeout_3", exp_q.size(), 0);
        tx_ready = 1'b1;
        send_rx(8'h55);
        tick(2);
        check("pkt_count_3", pkt_count, 3);

        // No ACK: original plus two retries of the same snapshot, then one fail pulse
        set_fields(2'd0, 2'd1, 2'd2, 2'd3, 8'h81, 8'h7E);
        for (int k = 0; k < 3; k++) push_packet();
        done0 = done_cnt; fail0 = fail_cnt; max_retry_seen = 0;
        pulse_send();
        tick(12);
        send_rx(8'h54);
        n = 0;
        while (fail_cnt == fail0 && n < 300) begin tick(); n++; end
        if (n >= 300) check("fail_wait_timeout", fail_cnt - fail0, 1);
        tick(30);
        check("fail_pulse_once", fail_cnt - fail0, 1);
        check("fail_no_done", done_cnt - done0, 0);
        check("retry_cnt_final", retry_cnt, 2);
        check("retry_max_seen", max_retry_seen, 2);
        check("retry_all_sent", exp_q.size(), 0);
        check("pkt_count_after_fail", pkt_count, 3);
        check("fail_idle_busy", busy, 0);

        // Three requests during a packet merge into a single pending packet
        set_fields(2'd3, 2'd2, 2'd1, 2'd0, 8'h12, 8'h34);
        push_packet();
        done0 = done_cnt;
        pulse_send();
        tick(2);
        set_fields(2'd1, 2'd1, 2'd0, 2'd2, 8'hA5, 8'h0F);
        push_packet();
        for (int k = 0; k < 3; k++) begin pulse_send(); tick(); end
        wait_q(8, 40, "drain_timeout_5a");
        send_rx(8'h55);
        wait_q(0, 40, "drain_timeout_5b");
        send_rx(8'h55);
        tick(25);
        check("pending_done", done_cnt - done0, 2);
        check("pending_count", pkt_count, 5);
        check("pending_idle", busy, 0);
        check("pending_retry", retry_cnt, 0);

        // Periodic trigger and reset in the middle of a packet
        set_fields(2'd1, 2'd2, 2'd3, 2'd2, 8'h11, 8'h22);
        rst_p = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            n = 0;
            while (!tx_valid_p && n < 150) begin tick(); n++; end
            check("period_first", n, 100);
            check("period_b0", tx_data_p, 8'hAA);
            check("period_busy", busy_p, 1);
            if (pass == 0) begin
                tick(4);
                check("period_b4", tx_data_p, pkt_byte(4, 2'd1, 2'd2, 2'd3, 2'd2, 8'h11, 8'h22));
                rst_p = 1'b1;
                tick();
                check("midrst_tx_valid", tx_valid_p, 0);
                check("midrst_tx_data", tx_data_p, 8'h00);
                check("midrst_busy", busy_p, 0);
                check("midrst_done", pkt_done_p, 0);
                check("midrst_fail", pkt_fail_p, 0);
                check("midrst_retry", retry_cnt_p, 0);
                check("midrst_count", pkt_count_p, 0);
                check("midrst_state", dbg_state_p, 0);
                rst_p = 1'b0;
            end
        end
        rst_p = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
